sitcp_tx_scheduler: RTL and testbench
=====================================

# sitcp_tx_scheduler

Packet-level TX scheduler between several user data sources and the SiTCP core TCP TX FIFO port (TX_WR/TX_DATA/TX_FULL). It grants one source per packet using round-robin and holds the grant until that source's last byte. It stalls all sources while no TCP connection is open, and drains a packet cleanly if the connection drops mid-packet. It sequences the close handshake by answering CLOSE_REQ with CLOSE_ACK only when no packet is in flight.

## Interface
- NUM_SRC, 4: number of sources, 2..16
- CLK  in  1  system clock, same clock as the SiTCP core
- RSTn  in  1  synchronous, active-low reset
- MAIN_OPEN_ACK  in  1  TCP connection established, from SiTCP
- CLOSE_REQ  in  1  close request, from SiTCP
- CLOSE_ACK  out  1  close acknowledge, to SiTCP
- TX_FULL  in  1  TX FIFO almost-full, from SiTCP
- TX_WR  out  1  TX byte write strobe, to SiTCP
- TX_DATA  out  8  TX byte, to SiTCP
- SRC_VALID  in  NUM_SRC  per-source byte valid
- SRC_DATA  in  8*NUM_SRC  per-source byte; source i occupies bits [8i+7:8i]
- SRC_LAST  in  NUM_SRC  per-source last byte of packet, qualified by valid
- SRC_READY  out  NUM_SRC  per-source ready
- GRANT  out  NUM_SRC  one-hot current owner, or 0
- BUSY  out  1  state is not IDLE
- PKT_CNT  out  16  packets completed to SiTCP; wraps at 0xFFFF->0

## Operation
- States: IDLE, HDR0, HDR1, DATA, DRAIN, CLOSE. HDR0 and HDR1 exist only with SITCP_TX_HDR_EN.
- IDLE transitions:
  - CLOSE_REQ=1 -> CLOSE. CLOSE_REQ has priority over new grants.
  - Otherwise, MAIN_OPEN_ACK=1 and any SRC_VALID -> register GRANT. The winner is the first valid source searching upward, with wrap, from (last winner + 1) mod NUM_SRC. Next state is HDR0 or DATA.
- Pointer: after reset the last winner is NUM_SRC-1, so source 0 has first priority. The pointer updates only when a grant is issued.
- DATA:
  - SRC_READY[g] = ~TX_FULL & MAIN_OPEN_ACK. All other ready bits are 0.
  - A transfer is SRC_VALID[g] & SRC_READY[g].
  - A transfer with SRC_LAST -> IDLE, GRANT=0, PKT_CNT+1.
  - MAIN_OPEN_ACK=0 with no transfer in that cycle -> DRAIN.
- DRAIN: SRC_READY[g]=1 and TX_WR=0, so bytes are discarded. On the transfer with SRC_LAST -> IDLE. PKT_CNT does not increment.
- CLOSE: CLOSE_ACK=1 while CLOSE_REQ=1. When CLOSE_REQ=0 -> IDLE and CLOSE_ACK=0.
- An in-flight packet completes (DATA) or drains (DRAIN) before CLOSE is entered. CLOSE_REQ seen in DATA is deferred until IDLE.
- While the state is not DATA or DRAIN, all SRC_READY bits are 0. While MAIN_OPEN_ACK=0 and the state is IDLE, no grant is issued and sources stall.
- TX_DATA equals the granted source's byte from the transfer cycle.

## Timing
- Reset values:
  - TX_WR=0, TX_DATA=0x00
  - CLOSE_ACK=0, GRANT=0, BUSY=0, PKT_CNT=0
  - all SRC_READY=0
  - state IDLE
- Reset has priority over all other inputs. Reset mid-packet abandons the packet with no further TX_WR. The source must discard its remainder.
- Arbitration: 1 cycle. The first data transfer can occur in the cycle after GRANT is registered (without header).
- TX_WR and TX_DATA are registered, with 1-cycle latency from the transfer or header cycle.
- SRC_READY is combinational from state, GRANT, TX_FULL and MAIN_OPEN_ACK. The 1-cycle write after TX_FULL rises is covered by SiTCP's almost-full margin.
- Throughput: 1 byte per cycle in DATA with TX_FULL=0. There is 1 idle cycle between packets (IDLE).
- CLOSE_ACK rises 1 cycle after the state enters CLOSE, and falls 1 cycle after CLOSE_REQ falls.

## Configuration
- SITCP_TX_HDR_EN defined:
  - Each packet is prefixed by 2 bytes: HDR0 writes 0xA5, then HDR1 writes {4'h0, source index}.
  - Each header byte is written only in a cycle with TX_FULL=0 and MAIN_OPEN_ACK=1.
  - MAIN_OPEN_ACK=0 during HDR0 or HDR1 -> DRAIN.
- Undefined: no header states; the path is IDLE -> DATA directly.

## Test plan
- Four sources each present a 3-byte packet simultaneously after reset -> grants in order 0,1,2,3; 12 TX_WR pulses; one idle cycle between packets; PKT_CNT=4.
- Source 2 streams a 10-byte packet while TX_FULL is toggled every 2 cycles -> all 10 bytes written exactly once and in order; no TX_WR in the cycle after TX_FULL is sampled high.
- MAIN_OPEN_ACK drops after byte 4 of an 8-byte packet -> TX_WR stops; remaining 4 bytes accepted with TX_WR=0; return to IDLE; PKT_CNT unchanged.
- CLOSE_REQ asserted mid-packet -> packet completes; CLOSE_ACK=1 one cycle after entering CLOSE; CLOSE_ACK=0 one cycle after CLOSE_REQ deasserts; no grant while in CLOSE.
- RSTn=0 for one cycle mid-packet -> all outputs return to reset values the next cycle; the next grant goes to source 0.
- With SITCP_TX_HDR_EN, source 3 sends 0x11,0x22 -> TX_DATA sequence is 0xA5, 0x03, 0x11, 0x22.

Source files
------------

// File: rtl/sitcp_tx_scheduler.sv
// Round-robin packet scheduler feeding the SiTCP TCP TX FIFO port (TX_WR/TX_DATA/TX_FULL).
// Define SITCP_TX_HDR_EN to prefix each packet with a 2-byte header (0xA5, source index).
module sitcp_tx_scheduler #(
  parameter int NUM_SRC = 4
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 MAIN_OPEN_ACK,
  input  logic                 CLOSE_REQ,
  output logic                 CLOSE_ACK,
  input  logic                 TX_FULL,
  output logic                 TX_WR,
  output logic [7:0]           TX_DATA,
  input  logic [NUM_SRC-1:0]   SRC_VALID,
  input  logic [8*NUM_SRC-1:0] SRC_DATA,
  input  logic [NUM_SRC-1:0]   SRC_LAST,
  output logic [NUM_SRC-1:0]   SRC_READY,
  output logic [NUM_SRC-1:0]   GRANT,
  output logic                 BUSY,
  output logic [15:0]          PKT_CNT,
  output logic [2:0]           DBG_STATE
);
  localparam int IW = $clog2(NUM_SRC);
  localparam logic [NUM_SRC-1:0] ONE = NUM_SRC'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR0  = 3'd1,
    HDR1  = 3'd2,
    DATA  = 3'd3,
    DRAIN = 3'd4,
    CLOSE = 3'd5
  } state_t;

  state_t             state_q;
  logic [NUM_SRC-1:0] grant_q;
  logic [IW-1:0]      owner_q;
  logic               tx_wr_q;
  logic [7:0]         tx_data_q;
  logic               close_ack_q;
  logic [15:0]        pkt_cnt_q;

  logic               xfer;
  logic               sel_last;
  logic [7:0]         sel_data;
  logic               win_found;
  logic [IW-1:0]      win_idx;

  // Handshake: a byte moves on a cycle where SRC_VALID[g] and SRC_READY[g] are both high.
  always_comb begin
    SRC_READY = '0;
    if (state_q == DATA)
      SRC_READY = grant_q & {NUM_SRC{~TX_FULL & MAIN_OPEN_ACK}};
    else if (state_q == DRAIN)
      SRC_READY = grant_q;
  end

  assign xfer = |(SRC_VALID & SRC_READY);

  always_comb begin
    sel_last = 1'b0;
    sel_data = 8'h00;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (IW'(i) == owner_q) begin
        sel_last = SRC_LAST[i];
        sel_data = SRC_DATA[8*i +: 8];
      end
    end
  end

  // owner_q keeps the last winner after the grant drops, so it doubles as the RR pointer.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(owner_q) + k) % NUM_SRC;
      if (!win_found && SRC_VALID[IW'(idx)]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= IW'(NUM_SRC - 1);
      tx_wr_q     <= 1'b0;
      tx_data_q   <= 8'h00;
      close_ack_q <= 1'b0;
      pkt_cnt_q   <= 16'h0000;
    end else begin
      tx_wr_q     <= 1'b0;
      close_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (CLOSE_REQ) begin
            state_q <= CLOSE;
          end else if (MAIN_OPEN_ACK && win_found) begin
            grant_q <= ONE << win_idx;
            owner_q <= win_idx;
`ifdef SITCP_TX_HDR_EN
            state_q <= HDR0;
`else
            state_q <= DATA;
`endif
          end
        end
`ifdef SITCP_TX_HDR_EN
        HDR0: begin
          if (!MAIN_OPEN_ACK) begin
            state_q <= DRAIN;
          end else if (!TX_FULL) begin
            tx_wr_q   <= 1'b1;
            tx_data_q <= 8'hA5;
            state_q   <= HDR1;
          end
        end
        HDR1: begin
          if (!MAIN_OPEN_ACK) begin
            state_q <= DRAIN;
          end else if (!TX_FULL) begin
            tx_wr_q   <= 1'b1;
            tx_data_q <= 8'(owner_q);
            state_q   <= DATA;
          end
        end
`endif
        DATA: begin
          if (xfer) begin
            tx_wr_q   <= 1'b1;
            tx_data_q <= sel_data;
            if (sel_last) begin
              state_q   <= IDLE;
              grant_q   <= '0;
              pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
          end else if (!MAIN_OPEN_ACK) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (xfer && sel_last) begin
            state_q <= IDLE;
            grant_q <= '0;
          end
        end
        CLOSE: begin
          if (CLOSE_REQ) close_ack_q <= 1'b1;
          else           state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign TX_WR     = tx_wr_q;
  assign TX_DATA   = tx_data_q;
  assign CLOSE_ACK = close_ack_q;
  assign GRANT     = grant_q;
  assign BUSY      = (state_q != IDLE);
  assign PKT_CNT   = pkt_cnt_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_sitcp_tx_scheduler.sv
// Bench for sitcp_tx_scheduler: directed scenarios plus random traffic, checked every cycle
// against a packet-level model (owner / drain / close bookkeeping and an expected byte queue).
module tb_sitcp_tx_scheduler;
  localparam int N = 4;
`ifdef SITCP_TX_HDR_EN
  localparam int HDR_N = 2;
`else
  localparam int HDR_N = 0;
`endif

  logic           CLK = 1'b0;
  logic           RSTn, MAIN_OPEN_ACK, CLOSE_REQ, CLOSE_ACK, TX_FULL, TX_WR, BUSY;
  logic [7:0]     TX_DATA;
  logic [N-1:0]   SRC_VALID, SRC_LAST, SRC_READY, GRANT;
  logic [8*N-1:0] SRC_DATA;
  logic [15:0]    PKT_CNT;
  logic [2:0]     DBG_STATE;

  sitcp_tx_scheduler #(.NUM_SRC(N)) dut (
    .CLK(CLK), .RSTn(RSTn), .MAIN_OPEN_ACK(MAIN_OPEN_ACK), .CLOSE_REQ(CLOSE_REQ),
    .CLOSE_ACK(CLOSE_ACK), .TX_FULL(TX_FULL), .TX_WR(TX_WR), .TX_DATA(TX_DATA),
    .SRC_VALID(SRC_VALID), .SRC_DATA(SRC_DATA), .SRC_LAST(SRC_LAST), .SRC_READY(SRC_READY),
    .GRANT(GRANT), .BUSY(BUSY), .PKT_CNT(PKT_CNT), .DBG_STATE(DBG_STATE)
  );

  always #5 CLK = ~CLK;

  // stimulus knobs and per-source packet queues ({last, byte})
  bit         rst_k, open_k, full_k, creq_k, gap_en;
  logic [8:0] sq [N][$];
  int         pops [N];

  // packet-level model
  int          m_owner, m_hdr, m_last_win;
  bit          m_spoil, m_close;
  logic [15:0] m_pkt;
  logic [N-1:0] e_grant;
  bit          e_tx_wr, e_close_ack, e_busy;
  logic [7:0]  exp_q [$];

  // scoreboard bookkeeping
  int          n_checks = 0, n_pass = 0, cyc = 0, wr_cnt = 0;
  logic [7:0]  tx_log [$];
  int          grant_log [$];
  logic [N-1:0] prev_grant = '0;
  logic [15:0] prev_pkt = '0;
  logic        prev_ack = 1'b0;
  int          pkt_chg_cyc = 0, ack_rise_cyc = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    m_owner = -1; m_hdr = 0; m_last_win = N - 1; m_spoil = 0; m_close = 0; m_pkt = '0;
    exp_q.delete();
    e_tx_wr = 0; e_close_ack = 0; e_grant = '0; e_busy = 0;
  endtask

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    r = '0;
    if (!m_close && m_owner >= 0 && m_hdr == 0) r[m_owner] = m_spoil ? 1'b1 : (!full_k && open_k);
    return r;
  endfunction

  task automatic model_step();
    logic [N-1:0] r;
    int o;
    r = model_ready();
    o = 0;
    e_tx_wr = 0; e_close_ack = 0;
    if (m_close) begin
      if (creq_k) e_close_ack = 1; else m_close = 0;
    end else if (m_owner < 0) begin
      if (creq_k) m_close = 1;
      else if (open_k && (|SRC_VALID)) begin
        for (int k = 1; k <= N; k++) begin
          o = (m_last_win + k) % N;
          if (SRC_VALID[o]) break;
        end
        m_owner = o; m_last_win = o; m_hdr = HDR_N; m_spoil = 0;
      end
    end else if (m_hdr > 0) begin
      if (!open_k) begin m_spoil = 1; m_hdr = 0; end
      else if (!full_k) begin
        e_tx_wr = 1;
        exp_q.push_back((m_hdr == HDR_N) ? 8'hA5 : 8'(m_owner));
        m_hdr--;
      end
    end else if (SRC_VALID[m_owner] && r[m_owner]) begin
      if (!m_spoil) begin e_tx_wr = 1; exp_q.push_back(SRC_DATA[8*m_owner +: 8]); end
      if (SRC_LAST[m_owner]) begin
        if (!m_spoil) m_pkt++;
        m_owner = -1;
      end
    end else if (!open_k) begin
      m_spoil = 1;
    end
    e_grant = '0;
    if (m_owner >= 0) e_grant[m_owner] = 1'b1;
    e_busy = (m_owner >= 0) || m_close;
  endtask

  task automatic drive();
    logic [8:0] hd;
    RSTn = !rst_k; MAIN_OPEN_ACK = open_k; TX_FULL = full_k; CLOSE_REQ = creq_k;
    for (int i = 0; i < N; i++) begin
      if (sq[i].size() > 0 && !rst_k && (!gap_en || $urandom_range(0, 3) != 0)) begin
        hd = sq[i][0];
        SRC_VALID[i] = 1'b1; SRC_DATA[8*i +: 8] = hd[7:0]; SRC_LAST[i] = hd[8];
      end else begin
        SRC_VALID[i] = 1'b0; SRC_DATA[8*i +: 8] = 8'($urandom_range(0, 255));
        SRC_LAST[i] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic drop_packet(int o);
    logic [8:0] hd;
    while (sq[o].size() > 0) begin
      hd = sq[o].pop_front();
      if (hd[8]) break;
    end
  endtask

  // one clock: drive at negedge, check ready, step model, check registered outputs after posedge
  task automatic cycle();
    bit f;
    logic [7:0] eb;
    drive();
    #1;
    if (!rst_k) chk("src_ready", 32'(SRC_READY), 32'(model_ready()));
    f = full_k;
    if (rst_k) begin
      if (m_owner >= 0) drop_packet(m_owner);
      model_reset();
    end else begin
      model_step();
      for (int i = 0; i < N; i++)
        if (SRC_VALID[i] && SRC_READY[i]) begin void'(sq[i].pop_front()); pops[i]++; end
    end
    @(posedge CLK); #1;
    chk("tx_wr", 32'(TX_WR), 32'(e_tx_wr));
    if (e_tx_wr) begin eb = exp_q.pop_front(); chk("tx_data", 32'(TX_DATA), 32'(eb)); end
    if (rst_k) chk("tx_data_rst", 32'(TX_DATA), 32'h0);
    if (TX_WR) begin
      wr_cnt++; tx_log.push_back(TX_DATA);
      chk("wr_after_full", 32'(TX_WR & f), 32'h0);
    end
    chk("grant", 32'(GRANT), 32'(e_grant));
    chk("busy", 32'(BUSY), 32'(e_busy));
    chk("pkt_cnt", 32'(PKT_CNT), 32'(m_pkt));
    chk("close_ack", 32'(CLOSE_ACK), 32'(e_close_ack));
    if (GRANT != '0 && prev_grant == '0)
      for (int i = 0; i < N; i++) if (GRANT[i]) grant_log.push_back(i);
    prev_grant = GRANT;
    if (PKT_CNT != prev_pkt) pkt_chg_cyc = cyc;
    prev_pkt = PKT_CNT;
    if (CLOSE_ACK && !prev_ack) ack_rise_cyc = cyc;
    prev_ack = CLOSE_ACK;
    cyc++;
    @(negedge CLK);
  endtask

  function automatic bit all_done();
    for (int i = 0; i < N; i++) if (sq[i].size() > 0) return 0;
    return (m_owner < 0) && !m_close;
  endfunction

  task automatic run_until_done(string name, int budget, bit toggle_full);
    int n;
    n = 0;
    while (!all_done() && n < budget) begin
      if (toggle_full) full_k = ((n / 2) % 2) == 1;
      cycle(); n++;
    end
    full_k = 0;
    n_checks++;
    if (all_done()) n_pass++;
    else $display("FAIL %s: timeout after %0d cycles, required all packets finished", name, budget);
    cycle();
  endtask

  task automatic wait_pops(string name, int s, int target, int budget);
    int n;
    n = 0;
    while (pops[s] < target && n < budget) begin cycle(); n++; end
    n_checks++;
    if (pops[s] >= target) n_pass++;
    else $display("FAIL %s: got %0d pops, required %0d", name, pops[s], target);
  endtask

  task automatic load_pkt(int s, int len, int base);
    for (int j = 0; j < len; j++) begin
      logic [7:0] b;
      b = (base < 0) ? 8'($urandom_range(0, 255)) : 8'(base + j);
      sq[s].push_back({(j == len - 1), b});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int mark_tx, mark_g, n;
    model_reset();
    RSTn = 1'b0; MAIN_OPEN_ACK = 1'b0; CLOSE_REQ = 1'b0; TX_FULL = 1'b0;
    SRC_VALID = '0; SRC_DATA = '0; SRC_LAST = '0;
    for (int i = 0; i < N; i++) pops[i] = 0;
    @(negedge CLK);

    // reset values
    rst_k = 1; cycle(); cycle(); rst_k = 0;
    chk("rst_tx_wr", 32'(TX_WR), 32'h0);
    chk("rst_tx_data", 32'(TX_DATA), 32'h0);
    chk("rst_close_ack", 32'(CLOSE_ACK), 32'h0);
    chk("rst_grant", 32'(GRANT), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    chk("rst_pkt_cnt", 32'(PKT_CNT), 32'h0);
    chk("rst_src_ready", 32'(SRC_READY), 32'h0);
    chk("rst_state", 32'(DBG_STATE), 32'h0);

    // four simultaneous 3-byte packets
    open_k = 1; mark_g = grant_log.size(); wr_cnt = 0;
    for (int s = 0; s < N; s++) load_pkt(s, 3, 16 * s);
    run_until_done("four_src", 100, 0);
    chk("four_src_wr_cnt", 32'(wr_cnt), 32'(12 + 4 * HDR_N));
    chk("four_src_pkt_cnt", 32'(PKT_CNT), 32'd4);
    chk("four_src_grants", 32'(grant_log.size() - mark_g), 32'd4);
    if (grant_log.size() - mark_g == 4)
      for (int s = 0; s < 4; s++) chk("four_src_order", 32'(grant_log[mark_g + s]), 32'(s));

    // 10-byte packet with TX_FULL toggling
    mark_tx = tx_log.size(); wr_cnt = 0;
    load_pkt(2, 10, 8'h40);
    run_until_done("full_toggle", 200, 1);
    chk("full_toggle_wr_cnt", 32'(wr_cnt), 32'(10 + HDR_N));
    chk("full_toggle_pkt_cnt", 32'(PKT_CNT), 32'd5);
    if (tx_log.size() - mark_tx == 10 + HDR_N) begin
`ifdef SITCP_TX_HDR_EN
      chk("full_toggle_hdr0", 32'(tx_log[mark_tx]), 32'hA5);
      chk("full_toggle_hdr1", 32'(tx_log[mark_tx + 1]), 32'h02);
`endif
      for (int j = 0; j < 10; j++)
        chk("full_toggle_byte", 32'(tx_log[mark_tx + HDR_N + j]), 32'(8'h40 + j));
    end

    // connection drops after byte 4 of an 8-byte packet
    mark_tx = tx_log.size(); pops[1] = 0;
    load_pkt(1, 8, 8'h80);
    wait_pops("drop_wait", 1, 4, 100);
    open_k = 0;
    run_until_done("drop_drain", 100, 0);
    chk("drop_wr_cnt", 32'(tx_log.size() - mark_tx), 32'(4 + HDR_N));
    chk("drop_pkt_cnt", 32'(PKT_CNT), 32'd5);
    chk("drop_idle", 32'(BUSY), 32'h0);
    open_k = 1;

    // close request mid-packet
    pops[0] = 0;
    load_pkt(0, 5, 8'hC0);
    wait_pops("close_wait", 0, 2, 100);
    creq_k = 1;
    load_pkt(3, 2, 8'hD0);
    n = 0;
    while (!CLOSE_ACK && n < 50) begin cycle(); n++; end
    chk("close_ack_high", 32'(CLOSE_ACK), 32'h1);
    chk("close_pkt_done", 32'(PKT_CNT), 32'd6);
    chk("close_ack_delay", 32'(ack_rise_cyc - pkt_chg_cyc), 32'd2);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("close_no_grant", 32'(GRANT), 32'h0);
    end
    creq_k = 0;
    cycle();
    chk("close_ack_fall", 32'(CLOSE_ACK), 32'h0);
    run_until_done("after_close", 100, 0);
    chk("after_close_grant", 32'(grant_log[grant_log.size() - 1]), 32'd3);

    // reset mid-packet
    pops[1] = 0;
    load_pkt(1, 6, 8'hE0);
    wait_pops("rst_wait", 1, 2, 100);
    rst_k = 1; cycle(); rst_k = 0;
    chk("midrst_tx_wr", 32'(TX_WR), 32'h0);
    chk("midrst_grant", 32'(GRANT), 32'h0);
    chk("midrst_busy", 32'(BUSY), 32'h0);
    chk("midrst_pkt_cnt", 32'(PKT_CNT), 32'h0);
    chk("midrst_src_ready", 32'(SRC_READY), 32'h0);
    mark_g = grant_log.size();
    load_pkt(3, 3, 8'h30);
    load_pkt(0, 3, 8'h00);
    run_until_done("after_rst", 100, 0);
    chk("after_rst_grants", 32'(grant_log.size() - mark_g), 32'd2);
    if (grant_log.size() - mark_g == 2) begin
      chk("after_rst_first", 32'(grant_log[mark_g]), 32'd0);
      chk("after_rst_second", 32'(grant_log[mark_g + 1]), 32'd3);
    end

    // source 3 sends 0x11, 0x22
    mark_tx = tx_log.size();
    sq[3].push_back(9'h011);
    sq[3].push_back(9'h122);
    run_until_done("src3_pkt", 50, 0);
    chk("src3_len", 32'(tx_log.size() - mark_tx), 32'(2 + HDR_N));
    if (tx_log.size() - mark_tx == 2 + HDR_N) begin
`ifdef SITCP_TX_HDR_EN
      chk("src3_hdr0", 32'(tx_log[mark_tx]), 32'hA5);
      chk("src3_hdr1", 32'(tx_log[mark_tx + 1]), 32'h03);
`endif
      chk("src3_b0", 32'(tx_log[mark_tx + HDR_N]), 32'h11);
      chk("src3_b1", 32'(tx_log[mark_tx + HDR_N + 1]), 32'h22);
    end

    // random traffic
    gap_en = 1;
    for (int c = 0; c < 2500; c++) begin
      int s;
      s = $urandom_range(0, N - 1);
      if ($urandom_range(0, 9) < 3 && sq[s].size() < 12) load_pkt(s, $urandom_range(1, 6), -1);
      full_k = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) < 3) open_k = !open_k;
      if (!creq_k) creq_k = ($urandom_range(0, 99) == 0);
      else         creq_k = ($urandom_range(0, 4) != 0);
      cycle();
    end
    gap_en = 0; open_k = 1; full_k = 0; creq_k = 0;
    run_until_done("random_drain", 3000, 0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
